gecko_reg_scoreboard: RTL and testbench
=======================================

Name: gecko_reg_scoreboard

Overview:
Register-file plus write scoreboard at the writeback end of the decode/writeback status protocol. Decode issues a destination register and the block marks it pending. Writeback retires the register with its value, which clears the pending mark and updates the 32x32 register file. The block drives the per-register status array and the read data that decode consumes.

Parameters:
REG_RESET_VALUE, 32'h0000_0000, value loaded into every register x1..x31 on reset.
ERROR_STICKY, 1, 1: underflow_error holds until reset; 0: underflow_error pulses for one cycle.

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-low
issue_valid  in  1  decode requests to mark a destination pending
issue_ready  out  1  scoreboard accepts issue this cycle
issue_reg_addr  in  5  destination register of issued instruction
wb_valid  in  1  writeback retiring one write; always accepted, no ready
wb_reg_addr  in  5  retired register address
wb_value  in  32  retired result value
rs1_addr  in  5  read address 1
rs2_addr  in  5  read address 2
rs1_value  out  32  combinational read data 1
rs2_value  out  32  combinational read data 2
reg_status  out  32*STATUS_W  flattened status array, entry i at bits [i*STATUS_W +: STATUS_W]
underflow_error  out  1  retire seen for a register with zero outstanding writes

Behaviour:
- Reset (rst==0 at clk edge): all counters=0; reg_status all GECKO_REG_STATUS_VALID; x1..x31=REG_RESET_VALUE; underflow_error=0. Reset mid-operation discards all pending state. In-flight writebacks arriving after reset follow the count==0 rule below.
- Per-register counter, STATUS_W bits (package constant, 2). Status equals the counter value. 0 means VALID. Values 1..max-1 mean PENDING. All-ones means GECKO_REG_STATUS_FULL.
- x0: never tracked. Status is constantly VALID, reads return 0, issues and writebacks to x0 are ignored, and issue_ready=1 for x0.
- Handshake: issue_ready = (counter[issue_reg_addr] != FULL) || (wb_valid && wb_reg_addr==issue_reg_addr). An issue fires on issue_valid && issue_ready. issue_ready must not depend on issue_valid.
- Counter update, registered with 1-cycle latency:
  - issue fire only: +1.
  - wb only: -1.
  - issue fire and wb to the same register in the same cycle: unchanged.
  - issue fire and wb to different registers: each register updated independently.
- Underflow: a wb_valid to register r with counter 0, not offset by a same-cycle issue to r, leaves the counter at 0 (no wrap) and raises underflow_error on the next cycle. The value is still written.
- Register write: on wb_valid with a nonzero address, storage[wb_reg_addr] <= wb_value, visible on reads the next cycle.
- Reads are combinational from storage. Status changes are visible on reg_status the cycle after the edge that caused them.
- Counter saturation is impossible: issue at FULL is blocked unless a same-register retire offsets it.

Optional Feature:
GECKO_REG_FILE_BYPASS_EN:
- Defined: if wb_valid && wb_reg_addr==rsN_addr && rsN_addr!=0, rsN_value=wb_value in the same cycle (write-through bypass). Same-cycle writeback is also reflected on reg_status combinationally, i.e. the entry shows counter-1.
- Undefined: reads and status both reflect writeback one cycle later, as specified above.

Decomposition:
- Shared package gecko additions: STATUS_W constant; gecko_reg_status_t, as logic [STATUS_W-1:0]; GECKO_REG_STATUS_VALID (0); GECKO_REG_STATUS_FULL (all ones); gecko_reg_file_status_t unpacked [32] array type, shared with decode.
- One sub-module, gecko_reg_status_counter: a single up/down saturating counter with inc, dec, count and underflow outputs, instantiated 31 times with a generate loop.
- Storage and read muxing stay in the top module.

Test Plan:
1. Reset then read all: rs1_addr=5, rs2_addr=0 -> rs1_value=REG_RESET_VALUE, rs2_value=0, reg_status all 0, underflow_error=0.
2. Issue x3 three times, no wb -> status[3] = 1, 2, then 3 (FULL); issue_ready=0 for x3 while FULL; issue to x4 still accepted.
3. x3 FULL; same cycle issue x3 and wb x3 with value 32'hDEAD_BEEF -> issue fires, status[3] stays 3, next cycle rs1 read of x3 returns 32'hDEAD_BEEF.
4. wb to x7 with counter 0 -> status[7] stays 0, value written, underflow_error=1 next cycle; it remains 1 if ERROR_STICKY=1, else returns to 0 after one cycle.
5. Issue and wb to x0 with value 32'h1234 -> x0 reads 0, status[0]=0, no error.
6. With GECKO_REG_FILE_BYPASS_EN: wb x9 with value 32'h55 and rs2_addr=9 in the same cycle -> rs2_value=32'h55 that cycle. Without the macro, the old value is returned that cycle and 32'h55 the next.

Source files
------------

// File: rtl/gecko_reg_scoreboard_pkg.sv
// Shared register-status types for the gecko decode/writeback scoreboard.
package gecko_reg_scoreboard_pkg;

  localparam int unsigned STATUS_W = 2;

  typedef logic [STATUS_W-1:0] gecko_reg_status_t;

  localparam gecko_reg_status_t GECKO_REG_STATUS_VALID = '0;
  localparam gecko_reg_status_t GECKO_REG_STATUS_FULL  = '1;

  typedef gecko_reg_status_t gecko_reg_file_status_t [32];

endpackage

// File: rtl/gecko_reg_status_counter.sv
// Outstanding-write counter for one architectural register.
module gecko_reg_status_counter
  import gecko_reg_scoreboard_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic              dec,
  output gecko_reg_status_t count,
  output logic              underflow
);

  gecko_reg_status_t count_q;
  gecko_reg_status_t count_d;

  always_comb begin
    count_d   = count_q;
    underflow = 1'b0;
    case ({inc, dec})
      2'b10: begin
        if (count_q != GECKO_REG_STATUS_FULL) count_d = count_q + 1'b1;
      end
      2'b01: begin
        // A retire with nothing outstanding holds at zero and is flagged.
        if (count_q == GECKO_REG_STATUS_VALID) underflow = 1'b1;
        else count_d = count_q - 1'b1;
      end
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) count_q <= GECKO_REG_STATUS_VALID;
    else      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/gecko_reg_scoreboard.sv
// Register file plus per-register write scoreboard at writeback.
// Optional macro GECKO_REG_FILE_BYPASS_EN: same-cycle writeback bypass on reads/status.
module gecko_reg_scoreboard
  import gecko_reg_scoreboard_pkg::*;
#(
  parameter logic [31:0] REG_RESET_VALUE = 32'h0000_0000,
  parameter bit          ERROR_STICKY    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [4:0]              issue_reg_addr,
  input  logic                    wb_valid,
  input  logic [4:0]              wb_reg_addr,
  input  logic [31:0]             wb_value,
  input  logic [4:0]              rs1_addr,
  input  logic [4:0]              rs2_addr,
  output logic [31:0]             rs1_value,
  output logic [31:0]             rs2_value,
  output logic [32*STATUS_W-1:0]  reg_status,
  output logic                    underflow_error
);

  gecko_reg_file_status_t counts;
  logic [31:0]            uf_vec;
  logic [31:0]            regs [1:31];
  logic                   issue_fire;
  logic                   wb_same;

  assign wb_same     = wb_valid && (wb_reg_addr == issue_reg_addr);
  assign issue_ready = (issue_reg_addr == 5'd0) ||
                       (counts[issue_reg_addr] != GECKO_REG_STATUS_FULL) || wb_same;
  assign issue_fire  = issue_valid && issue_ready;

  assign counts[0] = GECKO_REG_STATUS_VALID;
  assign uf_vec[0] = 1'b0;

  for (genvar i = 1; i < 32; i++) begin : g_cnt
    gecko_reg_status_counter u_cnt (
      .clk       (clk),
      .rst       (rst),
      .inc       (issue_fire && (issue_reg_addr == 5'(i))),
      .dec       (wb_valid && (wb_reg_addr == 5'(i))),
      .count     (counts[i]),
      .underflow (uf_vec[i])
    );
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      underflow_error <= 1'b0;
    end else if (ERROR_STICKY) begin
      underflow_error <= underflow_error || (uf_vec != '0);
    end else begin
      underflow_error <= (uf_vec != '0);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int unsigned i = 1; i < 32; i++) regs[i] <= REG_RESET_VALUE;
    end else if (wb_valid && (wb_reg_addr != 5'd0)) begin
      regs[wb_reg_addr] <= wb_value;
    end
  end

  function automatic logic [31:0] read_port(input logic [4:0] addr);
    logic [31:0] v;
    v = '0;
    if (addr != 5'd0) begin
      v = regs[addr];
`ifdef GECKO_REG_FILE_BYPASS_EN
      if (wb_valid && (wb_reg_addr == addr)) v = wb_value;
`endif
    end
    return v;
  endfunction

  assign rs1_value = read_port(rs1_addr);
  assign rs2_value = read_port(rs2_addr);

  always_comb begin
    reg_status = '0;
    for (int unsigned i = 0; i < 32; i++) begin
`ifdef GECKO_REG_FILE_BYPASS_EN
      // Show the retire early; the counter itself never goes below zero.
      if (wb_valid && (wb_reg_addr == 5'(i)) && (counts[i] != GECKO_REG_STATUS_VALID))
        reg_status[i*STATUS_W +: STATUS_W] = counts[i] - 1'b1;
      else
        reg_status[i*STATUS_W +: STATUS_W] = counts[i];
`else
      reg_status[i*STATUS_W +: STATUS_W] = counts[i];
`endif
    end
  end

endmodule

// File: tb/tb_gecko_reg_scoreboard.sv
// Directed self-checking bench for gecko_reg_scoreboard.
module tb_gecko_reg_scoreboard;
  import gecko_reg_scoreboard_pkg::*;

  localparam logic [31:0] RST_VAL = 32'hA5A5_0001;
  localparam bit          STICKY  = 1'b1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   issue_valid;
  logic                   issue_ready;
  logic [4:0]             issue_reg_addr;
  logic                   wb_valid;
  logic [4:0]             wb_reg_addr;
  logic [31:0]            wb_value;
  logic [4:0]             rs1_addr;
  logic [4:0]             rs2_addr;
  logic [31:0]            rs1_value;
  logic [31:0]            rs2_value;
  logic [32*STATUS_W-1:0] reg_status;
  logic                   underflow_error;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gecko_reg_scoreboard #(
    .REG_RESET_VALUE (RST_VAL),
    .ERROR_STICKY    (STICKY)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .issue_valid     (issue_valid),
    .issue_ready     (issue_ready),
    .issue_reg_addr  (issue_reg_addr),
    .wb_valid        (wb_valid),
    .wb_reg_addr     (wb_reg_addr),
    .wb_value        (wb_value),
    .rs1_addr        (rs1_addr),
    .rs2_addr        (rs2_addr),
    .rs1_value       (rs1_value),
    .rs2_value       (rs2_value),
    .reg_status      (reg_status),
    .underflow_error (underflow_error)
  );

  function automatic logic [31:0] st(input int idx);
    return 32'(reg_status[idx*STATUS_W +: STATUS_W]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue_valid = 1'b0; issue_reg_addr = '0;
    wb_valid = 1'b0; wb_reg_addr = '0; wb_value = '0;
  endtask

  initial begin
    rst = 1'b0; rs1_addr = '0; rs2_addr = '0;
    idle();
    tick(); tick();
    rst = 1'b1;

    // Reset state
    rs1_addr = 5'd5; rs2_addr = 5'd0;
    #1;
    check("rst_rs1", rs1_value, RST_VAL);
    check("rst_rs2", rs2_value, 32'h0);
    check("rst_status_lo", reg_status[31:0], 32'h0);
    check("rst_status_hi", reg_status[63:32], 32'h0);
    check("rst_uf", 32'(underflow_error), 32'h0);

    // Fill x3 to FULL
    issue_valid = 1'b1; issue_reg_addr = 5'd3;
    #1 check("x3_ready0", 32'(issue_ready), 32'h1);
    tick(); check("x3_st1", st(3), 32'd1);
    tick(); check("x3_st2", st(3), 32'd2);
    tick(); check("x3_st3", st(3), 32'd3);
    check("x3_full_ready", 32'(issue_ready), 32'h0);
    tick(); check("x3_full_hold", st(3), 32'd3);
    issue_reg_addr = 5'd4;
    #1 check("x4_ready", 32'(issue_ready), 32'h1);
    tick(); check("x4_st1", st(4), 32'd1);

    // Issue + retire same register while FULL
    issue_reg_addr = 5'd3; wb_valid = 1'b1; wb_reg_addr = 5'd3; wb_value = 32'hDEAD_BEEF;
    #1 check("x3_offset_ready", 32'(issue_ready), 32'h1);
    tick(); idle();
    rs1_addr = 5'd3;
    #1;
    check("x3_offset_st", st(3), 32'd3);
    check("x3_read", rs1_value, 32'hDEAD_BEEF);

    // Issue and retire to different registers
    issue_valid = 1'b1; issue_reg_addr = 5'd5; wb_valid = 1'b1; wb_reg_addr = 5'd4; wb_value = 32'h4444;
    tick(); idle();
    check("x5_st", st(5), 32'd1);
    check("x4_st0", st(4), 32'd0);
    check("x4_no_uf", 32'(underflow_error), 32'h0);

    // Underflow on x7
    wb_valid = 1'b1; wb_reg_addr = 5'd7; wb_value = 32'h7777_0007;
    tick(); idle();
    rs1_addr = 5'd7;
    #1;
    check("x7_st", st(7), 32'd0);
    check("x7_uf", 32'(underflow_error), 32'h1);
    check("x7_read", rs1_value, 32'h7777_0007);
    tick();
    check("x7_uf_sticky", 32'(underflow_error), STICKY ? 32'h1 : 32'h0);
    wb_valid = 1'b1; wb_reg_addr = 5'd3; wb_value = 32'h3;
    tick(); idle();
    check("x3_dec", st(3), 32'd2);

    // Reset mid-operation
    rst = 1'b0;
    tick();
    rst = 1'b1;
    rs1_addr = 5'd7;
    #1;
    check("rst2_uf", 32'(underflow_error), 32'h0);
    check("rst2_x3", st(3), 32'd0);
    check("rst2_x7", rs1_value, RST_VAL);

    // x0 is never tracked
    issue_valid = 1'b1; issue_reg_addr = 5'd0; wb_valid = 1'b1; wb_reg_addr = 5'd0; wb_value = 32'h1234;
    #1 check("x0_ready", 32'(issue_ready), 32'h1);
    tick(); idle();
    rs1_addr = 5'd0;
    #1;
    check("x0_read", rs1_value, 32'h0);
    check("x0_st", st(0), 32'd0);
    check("x0_uf", 32'(underflow_error), 32'h0);

    // Same-cycle read of a register being written
    rs2_addr = 5'd9; wb_valid = 1'b1; wb_reg_addr = 5'd9; wb_value = 32'h55;
    #1;
`ifdef GECKO_REG_FILE_BYPASS_EN
    check("x9_same_cycle", rs2_value, 32'h55);
`else
    check("x9_same_cycle", rs2_value, RST_VAL);
`endif
    tick(); idle();
    check("x9_next", rs2_value, 32'h55);
    check("x9_uf", 32'(underflow_error), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
